pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised elastic pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, and a freeze (stall) input. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries the packed stage payload (PC, control, operands). It sustains one transfer per cycle without a combinational ready path from downstream to upstream. A saturating freeze-cycle counter is exposed for performance debug.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (>=1)
- RESET_VAL, 0, WIDTH-bit value driven on out_data at reset, after flush, and whenever the stage holds a bubble
- CNT_W, 16, width of stall_cnt (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous squash of all held entries
- freeze  input  1  hold all state; both handshakes blocked
- in_valid  input  1  upstream has a payload
- in_ready  output  1  stage can accept this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage presents a payload
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  payload presented downstream
- occupancy  output  2  number of held entries, 0..2
- stall_cnt  output  CNT_W  saturating count of frozen cycles

## Operation
- Storage: main register (main_valid, main_data) drives the outputs. Skid register (skid_valid, skid_data) is internal.
- States are derived from the valid bits: EMPTY (0,0), ONE (1,0), FULL (1,1). The state (0,1) is illegal and never reached.
- in_ready = ~skid_valid & ~freeze & ~flush.
- out_valid = main_valid & ~freeze.
- out_data = main_data.
- occupancy = main_valid + skid_valid.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Per-edge priority: rst > flush > freeze > normal operation.
- rst (async): main_valid = skid_valid = 0; main_data = skid_data = RESET_VAL; stall_cnt = 0.
- flush (sync): both valids cleared, both data registers set to RESET_VAL, no push. stall_cnt is not incremented and keeps its value.
- freeze without flush: every register holds; stall_cnt increments, saturating at all-ones.
- Transitions in normal operation (no flush, no freeze):
  - EMPTY, push -> ONE; main_data = in_data.
  - ONE, push & pop -> ONE; main_data = in_data.
  - ONE, push & ~pop -> FULL; skid_data = in_data.
  - ONE, ~push & pop -> EMPTY; main_data = RESET_VAL.
  - FULL (no push is possible), pop -> ONE; main_data = skid_data, skid_data = RESET_VAL.
  - Any state with no push and no pop holds.
- The payload is never modified, reordered, duplicated, or dropped except by flush.

## Timing
- Reset values: out_valid 0, in_ready 1 (when freeze=0 and flush=0), out_data RESET_VAL, occupancy 0, stall_cnt 0.
- Latency: a payload pushed at edge N is on out_data with out_valid=1 from edge N to N+1. Latency is 1 cycle.
- Throughput: 1 payload/cycle while out_ready is held at 1.
- in_ready depends only on registered skid_valid plus the freeze and flush inputs. There is no combinational path from out_ready to in_ready.
- Downstream stall: when out_ready drops, at most one further payload is accepted into the skid register, then in_ready=0.
- freeze and flush act combinationally on the handshake outputs in the same cycle and take effect on state at the next edge.
- flush and freeze together: the flush wins; the stage is empty after the edge.
- Async rst asserted mid-transfer: outputs reach reset values immediately. There is no pending push after release.
- stall_cnt at all-ones stays at all-ones until rst.

## Test plan
- Streaming: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 on consecutive cycles with out_valid=1; occupancy stays 1.
- Backpressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0. Raise out_ready -> 0xA pops then 0xB pops, in order, with no loss.
- Flush with FULL state and in_valid=1 on the same cycle -> next cycle out_valid=0, out_data=RESET_VAL, occupancy=0, and the input is not accepted.
- Freeze for 3 cycles with occupancy=1 -> out_valid=0 and in_ready=0 during freeze, stored data unchanged, stall_cnt +3. After release the same payload is presented.
- Saturation: CNT_W=2, freeze for 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
- Async rst asserted between edges while FULL -> out_valid=0, out_data=RESET_VAL, and occupancy=0 before the next edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Function : Elastic pipeline stage register with valid/ready handshake,
//            two-entry skid buffer, synchronous flush, freeze (stall) input
//            and a saturating frozen-cycle counter for performance debug.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Occupancy states, encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_main_valid_nxt;
  logic [WIDTH-1:0] w_main_data_nxt;
  logic             w_skid_valid_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             w_push;
  logic             w_pop;

  // in_ready looks only at the registered skid bit, so out_ready never
  // reaches upstream combinationally.
  assign in_ready  = ~r_skid_valid & ~freeze & ~flush;
  assign out_valid = r_main_valid & ~freeze;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign stall_cnt = r_stall_cnt;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Next-state of the main/skid entries: flush squashes, freeze holds.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_main_data_nxt  = RESET_VAL;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = RESET_VAL;
    end else if (!freeze) begin
      case ({r_main_valid, r_skid_valid})
        ST_EMPTY: begin
          if (w_push) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_data_nxt  = in_data;
          end else if (w_push) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = in_data;
          end else if (w_pop) begin
            w_main_valid_nxt = 1'b0;
            w_main_data_nxt  = RESET_VAL;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_main_data_nxt  = r_skid_data;
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = RESET_VAL;
          end
        end
        default: begin
          w_main_valid_nxt = r_main_valid;
        end
      endcase
    end
  end

  // Entry registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RESET_VAL;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  // Frozen-cycle counter: counts freeze without flush, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (freeze && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
